// File: rtl/mips32_if.sv
// Register-file access bundle: two read ports and one write port.
// The master drives addresses and write data; the slave returns read data.
interface mips32_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [DATA_W-1:0] rddata1;
  logic [DATA_W-1:0] rddata2;
  logic [DATA_W-1:0] wrdata;
  logic [ADDR_W-1:0] sr1;
  logic [ADDR_W-1:0] sr2;
  logic [ADDR_W-1:0] dr;
  logic              write;

  modport master (
    output wrdata, sr1, sr2, dr, write,
    input  rddata1, rddata2
  );

  modport slave (
    input  wrdata, sr1, sr2, dr, write,
    output rddata1, rddata2
  );
endinterface

// File: rtl/mips32.sv
// MIPS32 general-purpose register file: 2 combinational reads, 1 write.
// Register 0 reads as zero; optional same-cycle write-to-read bypass.
module mips32 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  output logic [DATA_W-1:0] rddata1,
  output logic [DATA_W-1:0] rddata2,
  input  logic [DATA_W-1:0] wrdata,
  input  logic [ADDR_W-1:0] sr1,
  input  logic [ADDR_W-1:0] sr2,
  input  logic [ADDR_W-1:0] dr,
  input  logic              write,
  input  logic              reset,
  input  logic              clk
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic              wen;

  assign wen = write && !reset && (dr != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wen) begin
      regs_q[dr] <= wrdata;
    end
  end

  // Zero forcing is applied last so it also overrides the bypass.
  always_comb begin
    rddata1 = regs_q[sr1];
    if ((BYPASS != 0) && wen && (dr == sr1)) begin
      rddata1 = wrdata;
    end
    if (reset || (sr1 == '0)) begin
      rddata1 = '0;
    end
  end

  always_comb begin
    rddata2 = regs_q[sr2];
    if ((BYPASS != 0) && wen && (dr == sr2)) begin
      rddata2 = wrdata;
    end
    if (reset || (sr2 == '0)) begin
      rddata2 = '0;
    end
  end
endmodule

// File: tb/tb_mips32.sv
// Directed bench for mips32: bypass and no-bypass instances share stimulus.
// Expected values are queued at drive time and popped at sample time.
module tb_mips32;
  logic        clk;
  logic        reset;
  logic [31:0] nb_rd1;
  logic [31:0] nb_rd2;
  logic [31:0] exp_q[$];
  logic [31:0] mdl[32];
  int          n_tests;
  int          n_fail;

  mips32_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  mips32 #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_byp (
    .rddata1(bus.rddata1),
    .rddata2(bus.rddata2),
    .wrdata (bus.wrdata),
    .sr1    (bus.sr1),
    .sr2    (bus.sr2),
    .dr     (bus.dr),
    .write  (bus.write),
    .reset  (reset),
    .clk    (clk)
  );

  mips32 #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
    .rddata1(nb_rd1),
    .rddata2(nb_rd2),
    .wrdata (bus.wrdata),
    .sr1    (bus.sr1),
    .sr2    (bus.sr2),
    .dr     (bus.dr),
    .write  (bus.write),
    .reset  (reset),
    .clk    (clk)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic push(input logic [31:0] e);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    @(negedge clk);
    bus.dr = 5'(a);
    bus.wrdata = d;
    bus.write = 1'b1;
    @(posedge clk);
    #1;
    bus.write = 1'b0;
    if (a % 32 != 0) mdl[a % 32] = d;
  endtask

  task automatic sweep_zero(input string tag);
    for (int k = 0; k < 32; k++) begin
      bus.sr1 = 5'(k);
      bus.sr2 = 5'(31 - k);
      push(32'd0); push(32'd0); push(32'd0); push(32'd0);
      #1;
      chk({tag, "_b1"}, bus.rddata1);
      chk({tag, "_b2"}, bus.rddata2);
      chk({tag, "_n1"}, nb_rd1);
      chk({tag, "_n2"}, nb_rd2);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    reset = 1'b1;
    bus.write = 1'b0;
    bus.dr = '0;
    bus.wrdata = '0;
    bus.sr1 = 5'd1;
    bus.sr2 = 5'd2;
    #2;
    push(32'd0); chk("reset_state_1", bus.rddata1);
    push(32'd0); chk("reset_state_2", nb_rd2);
    #1 reset = 1'b0;

    // Asynchronous reset pulse with no clock edge in between.
    wr(4, 32'd44);
    wr(9, 32'd90);
    bus.sr1 = 5'd4;
    push(32'd44); #1 chk("preload_r4", bus.rddata1);
    @(negedge clk);
    #2 reset = 1'b1;
    #5 reset = 1'b0;
    sweep_zero("rst_clear");

    // Fill, then readback sweep with sr2 wrapping to 0.
    for (int k = 0; k < 32; k++) wr(k, 32'(10 * k));
    @(negedge clk);
    for (int k = 0; k < 32; k++) begin
      bus.sr1 = 5'(k);
      bus.sr2 = 5'(k + 1);
      push(mdl[k]); push(mdl[(k + 1) % 32]);
      push(mdl[k]); push(mdl[(k + 1) % 32]);
      #1;
      chk("fill_b1", bus.rddata1);
      chk("fill_b2", bus.rddata2);
      chk("fill_n1", nb_rd1);
      chk("fill_n2", nb_rd2);
    end

    // Register 0 write is discarded, even under bypass.
    @(negedge clk);
    bus.dr = 5'd0;
    bus.wrdata = 32'hDEADBEEF;
    bus.write = 1'b1;
    bus.sr1 = 5'd0;
    push(32'd0); #1 chk("r0_pre_byp", bus.rddata1);
    @(posedge clk);
    #1 bus.write = 1'b0;
    push(32'd0); push(32'd0);
    #1 chk("r0_post_byp", bus.rddata1);
    chk("r0_post_nb", nb_rd1);

    // Write disabled across three edges.
    wr(7, 32'd70);
    @(negedge clk);
    bus.dr = 5'd7;
    bus.wrdata = 32'd123;
    bus.write = 1'b0;
    bus.sr1 = 5'd7;
    repeat (3) @(posedge clk);
    push(32'd70); push(32'd70);
    #1 chk("wdis_byp", bus.rddata1);
    chk("wdis_nb", nb_rd1);

    // Same-cycle write and two reads of reg 5.
    wr(5, 32'd50);
    @(negedge clk);
    bus.dr = 5'd5;
    bus.wrdata = 32'd99;
    bus.write = 1'b1;
    bus.sr1 = 5'd5;
    bus.sr2 = 5'd5;
    push(32'd99); push(32'd99); push(32'd50); push(32'd50);
    #1;
    chk("same_pre_b1", bus.rddata1);
    chk("same_pre_b2", bus.rddata2);
    chk("same_pre_n1", nb_rd1);
    chk("same_pre_n2", nb_rd2);
    @(posedge clk);
    #1 bus.write = 1'b0;
    mdl[5] = 32'd99;
    push(32'd99); push(32'd99);
    #1 chk("same_post_b1", bus.rddata1);
    chk("same_post_n1", nb_rd1);

    // Reset mid-operation with a pending write to reg 3.
    @(negedge clk);
    bus.dr = 5'd3;
    bus.wrdata = 32'd777;
    bus.write = 1'b1;
    bus.sr1 = 5'd3;
    bus.sr2 = 5'd10;
    #2 reset = 1'b1;
    push(32'd0); push(32'd0); push(32'd0);
    #1 chk("rstop_b1", bus.rddata1);
    chk("rstop_b2", bus.rddata2);
    chk("rstop_n1", nb_rd1);
    @(posedge clk);
    @(negedge clk);
    push(32'd0); #1 chk("rstop_held_n1", nb_rd1);
    #1 reset = 1'b0;
    push(32'd777); push(32'd0); push(32'd0);
    #1 chk("rel_pre_b1", bus.rddata1);
    chk("rel_pre_n1", nb_rd1);
    chk("rel_pre_b2", bus.rddata2);
    @(posedge clk);
    #1 bus.write = 1'b0;
    push(32'd777); push(32'd777); push(32'd0);
    #1 chk("rel_post_b1", bus.rddata1);
    chk("rel_post_n1", nb_rd1);
    chk("rel_post_n2", nb_rd2);

    n_tests++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mips32.md
Name: mips32

Overview:
- 32-entry x 32-bit general-purpose register file for the MIPS32 pipelined datapath.
- Provides two combinational read ports (source operands rs/rt) and one synchronous write port (destination rd, writeback stage).
- Register 0 is hardwired to zero per MIPS convention.
- A parameterised write-to-read bypass lets a decode-stage read in the same cycle as a writeback see the new value.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth is 2**ADDR_W = 32.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored contents only.

Ports:
- clk  input  1  single clock; all writes occur on the rising edge.
- reset  input  1  asynchronous, active-high; clears all registers.
- rddata1  output  DATA_W  read data for address sr1.
- rddata2  output  DATA_W  read data for address sr2.
- wrdata  input  DATA_W  write data.
- sr1  input  ADDR_W  read address, port 1.
- sr2  input  ADDR_W  read address, port 2.
- dr  input  ADDR_W  write (destination) address.
- write  input  1  write enable, active-high.
- Positional port declaration order is fixed and required: rddata1, rddata2, wrdata, sr1, sr2, dr, write, reset, clk.

Behaviour:
- Storage: 32 registers of DATA_W bits, indexed 0..31.
- Reset:
  - reset=1 asynchronously clears all registers to 0, independent of clk.
  - While reset is held, writes are ignored and both read ports return 0.
  - Deasserting reset takes effect on the next rising edge; no extra latency.
- Write:
  - On rising clk with reset=0 and write=1, reg[dr] <= wrdata.
  - write=0: no register changes.
  - Write latency is one edge; new contents appear on the read ports after that edge.
- Register 0:
  - Writes with dr=0 are discarded.
  - Reads of address 0 always return 0, including under bypass.
- Read:
  - rddataN = reg[srN], purely combinational; address changes propagate with no clock.
  - Both ports are independent and may address the same register.
- Bypass (BYPASS=1):
  - If write=1, reset=0, dr!=0 and dr==srN, rddataN = wrdata combinationally, before the edge.
  - Applies to each port independently.
- BYPASS=0: reads return pre-edge contents until the edge commits the write.
- Address width: addresses are ADDR_W bits; wider values from a driver truncate modulo 32.
- Priority:
  - reset overrides write.
  - A write and two reads of the same address in one cycle are legal.
  - With bypass, the read ports show wrdata; without bypass, they show the old value, then the new value after the edge.
- Unknown or X-free behaviour:
  - Registers never hold X after the first reset.
  - Outputs are defined whenever the addresses are defined.
- Everything else is synchronous to the single clk; no multicycle paths.

Test Plan:
- Reset clear: pulse reset=1 for 5 ns mid-cycle without a clk edge, then read all 32 addresses -> every rddata1/rddata2 = 0.
- Fill and readback:
  - For k=0..31, dr=k, wrdata=10*k, write=1 for one rising edge each.
  - Then sweep sr1=k, sr2=(k+1) mod 32 -> rddata1=10*k for k>=1, reg[0]=0; rddata2=10*(k+1); sr2 wraps at k=31 and returns 0.
- Register 0 protection: write dr=0, wrdata=32'hDEADBEEF -> rddata1 with sr1=0 = 0, before and after the edge.
- Write disable: preload reg[7]=70; present dr=7, wrdata=123, write=0 across 3 edges -> reg[7] stays 70.
- Same-cycle read/write to reg[5], preloaded 50, with write=1, wrdata=99:
  - BYPASS=1 -> rddata1 = 99 before the edge.
  - BYPASS=0 -> rddata1 = 50 before the edge, 99 after.
- Reset mid-operation: fill registers, assert reset asynchronously between edges while write=1 to dr=3 -> all reads 0 immediately; after release, reg[3] is written only on the next edge with write=1.
